id_stage_pipe: RTL

Parametrised instruction-decode stage for the 5-stage MIPS core. It contains the integrated register file, the immediate extender, load-use hazard detection, and a registered ID/EX output with a valid/ready handshake and flush. It sits between the IF/ID register and the EX stage, and takes write-back from WB.

---
 rtl/id_stage_pipe_if.sv | 35 +++
 rtl/id_stage_pipe.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe_if.sv
// Bundles the instruction, ID/EX payload, flush and write-back signals of the decode stage.
interface id_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [4:0]        out_rt_addr;
    logic [4:0]        out_rd_addr;
    logic [5:0]        out_opcode;
    logic [10:0]       out_func;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, inst, out_ready, flush, wb_we, wb_addr, wb_data,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
               out_rt_addr, out_rd_addr, out_opcode, out_func, stall_cnt
    );

    modport slave (
        input  in_valid, inst, out_ready, flush, wb_we, wb_addr, wb_data,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
               out_rt_addr, out_rd_addr, out_opcode, out_func, stall_cnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register file, immediate extender, load-use
// hazard detection and a registered ID/EX output with valid/ready and flush.
module id_stage_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter bit          REG0_ZERO = 1'b1,
    parameter bit          WB_BYPASS = 1'b1,
    parameter logic [5:0]  LOAD_OP   = 6'h23,
    parameter int unsigned CNT_W     = 16
) (
    input logic            clk,
    input logic            rst_n,
    id_stage_pipe_if.slave bus
);
    localparam int unsigned REG_N = 32;

    logic [5:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [10:0] func;

    assign opcode  = bus.inst[31:26];
    assign rs_addr = bus.inst[25:21];
    assign rt_addr = bus.inst[20:16];
    assign rd_addr = bus.inst[15:11];
    assign func    = bus.inst[10:0];

    logic [DATA_W-1:0] rf [REG_N];
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;

    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load;
    logic              hz_c;
    logic              in_ready_c;

    logic [DATA_W-1:0] rs_q, rt_q, imm_q;
    logic [4:0]        rt_addr_q, rd_addr_q;
    logic [5:0]        opcode_q;
    logic [10:0]       func_q;

    // Read port: hard-wired r0, then optional forwarding of the WB write in flight.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [4:0]        a,
        input logic [DATA_W-1:0] raw,
        input logic              we,
        input logic [4:0]        wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] r;
        r = raw;
        if (REG0_ZERO && (a == 5'd0)) begin
            r = '0;
        end else if (WB_BYPASS && we && (wa == a)) begin
            r = wd;
        end
        return r;
    endfunction

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_we && !(REG0_ZERO && (bus.wb_addr == 5'd0))) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rs_data = read_sel(rs_addr, rf[rs_addr], bus.wb_we, bus.wb_addr, bus.wb_data);
        rt_data = read_sel(rt_addr, rf[rt_addr], bus.wb_we, bus.wb_addr, bus.wb_data);
    end

    // Jumps take the 26-bit target, logical immediates zero-extend, the rest sign-extend.
    always_comb begin
        imm = {{(DATA_W-16){bus.inst[15]}}, bus.inst[15:0]};
        case (opcode)
            6'h02, 6'h03:               imm = DATA_W'(bus.inst[25:0]);
            6'h0C, 6'h0D, 6'h0E, 6'h0F: imm = DATA_W'(bus.inst[15:0]);
            default:                    imm = {{(DATA_W-16){bus.inst[15]}}, bus.inst[15:0]};
        endcase
    end

    // Load-use: the held payload is a load whose destination the incoming inst reads.
    always_comb begin
        hz_c = bus.in_valid && valid_q && (opcode_q == LOAD_OP)
            && ((rt_addr_q != 5'd0) || !REG0_ZERO)
            && ((rs_addr == rt_addr_q) || (rt_addr == rt_addr_q));
    end

    // Handshake and bubble control; flush outranks both hazard and transfer.
    always_comb begin
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        in_ready_c = (!valid_q || bus.out_ready) && !hz_c && !bus.flush;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (bus.in_valid && in_ready_c) begin
            valid_d = 1'b1;
            load    = 1'b1;
        end else if (bus.out_ready || !valid_q) begin
            valid_d = 1'b0;
        end

        if (!bus.flush && hz_c && bus.out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            opcode_q  <= '0;
            func_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (load) begin
                rs_q      <= rs_data;
                rt_q      <= rt_data;
                imm_q     <= imm;
                rt_addr_q <= rt_addr;
                rd_addr_q <= rd_addr;
                opcode_q  <= opcode;
                func_q    <= func;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_q;
    assign bus.stall_cnt   = cnt_q;
    assign bus.out_rs_data = rs_q;
    assign bus.out_rt_data = rt_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_rt_addr = rt_addr_q;
    assign bus.out_rd_addr = rd_addr_q;
    assign bus.out_opcode  = opcode_q;
    assign bus.out_func    = func_q;
endmodule
